mac_array_ctrl: RTL

// Sequencer for the row x col systolic mac_tile array. Takes a start command (WS or OS

---
 rtl/mac_array_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/mac_array_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mac_array_ctrl
// Brief    : Sequencer for the systolic mac_tile array. Issues row-skewed
//            instructions and os_write enables, and gates L0 reads.
// Revision : 1.0
// ============================================================================
module mac_array_ctrl #(
  parameter int ROW    = 8,
  parameter int COL    = 8,
  parameter int CNT_BW = 8
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                start_i,
  input  logic                mode_i,
  input  logic [CNT_BW-1:0]   exec_len_i,
  input  logic                src_empty_i,
  output logic                src_rd_o,
  output logic [4*ROW-1:0]    inst_row_o,
  output logic [ROW-1:0]      os_write_row_o,
  output logic                busy_o,
  output logic                done_o
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WS_LOAD  = 3'd1,
    S_WS_EXEC  = 3'd2,
    S_OS_EXEC  = 3'd3,
    S_DRAIN    = 3'd4,
    S_OS_FLUSH = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  localparam logic [CNT_BW-1:0] c_row_len   = CNT_BW'(ROW);
  localparam logic [CNT_BW-1:0] c_drain_len = CNT_BW'(ROW + COL);
  localparam logic [CNT_BW-1:0] c_one       = CNT_BW'(1);
  localparam logic [3:0]        c_kernld    = 4'b0001;
  localparam logic [3:0]        c_ws_exec   = 4'b0010;
  localparam logic [3:0]        c_os_exec   = 4'b0100;
  localparam logic [3:0]        c_os_flush  = 4'b1000;

  state_t                 state_q;
  logic [CNT_BW-1:0]      cnt_q;
  logic [CNT_BW-1:0]      len_q;
  logic                   mode_q;
  logic [ROW-1:0][3:0]    inst_q;
  logic [ROW-1:0]         osw_q;

  logic                   w_feed;
  logic                   w_stall;
  logic                   w_last;
  logic [3:0]             inst0_d;
  logic                   osw0_d;

  assign w_feed  = (state_q == S_WS_LOAD) || (state_q == S_WS_EXEC) ||
                   (state_q == S_OS_EXEC);
  assign w_stall = w_feed & src_empty_i;
  assign w_last  = (cnt_q == c_one);

  // An empty source turns the feed instruction into a bubble for this cycle.
  always_comb begin
    inst0_d = 4'b0000;
    osw0_d  = 1'b0;
    case (state_q)
      S_WS_LOAD:  inst0_d = c_kernld;
      S_WS_EXEC:  inst0_d = c_ws_exec;
      S_OS_EXEC:  inst0_d = c_os_exec;
      S_OS_FLUSH: begin
        inst0_d = c_os_flush;
        osw0_d  = 1'b1;
      end
      default:    inst0_d = 4'b0000;
    endcase
    if (w_stall) begin
      inst0_d = 4'b0000;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      mode_q  <= 1'b0;
      inst_q  <= '0;
      osw_q   <= '0;
    end else begin
      inst_q[0] <= inst0_d;
      osw_q[0]  <= osw0_d;
      for (int r = 1; r < ROW; r++) begin
        inst_q[r] <= inst_q[r-1];
        osw_q[r]  <= osw_q[r-1];
      end

      // The counter is reloaded on every state entry and exits at 1, so it never wraps.
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            mode_q <= mode_i;
            len_q  <= exec_len_i;
            if (exec_len_i == '0) begin
              state_q <= S_DONE;
              cnt_q   <= c_one;
            end else if (mode_i) begin
              state_q <= S_OS_EXEC;
              cnt_q   <= exec_len_i;
            end else begin
              state_q <= S_WS_LOAD;
              cnt_q   <= c_row_len;
            end
          end
        end
        S_WS_LOAD: begin
          if (!w_stall) begin
            if (w_last) begin
              state_q <= S_WS_EXEC;
              cnt_q   <= len_q;
            end else begin
              cnt_q <= cnt_q - c_one;
            end
          end
        end
        S_WS_EXEC, S_OS_EXEC: begin
          if (!w_stall) begin
            if (w_last) begin
              state_q <= S_DRAIN;
              cnt_q   <= c_drain_len;
            end else begin
              cnt_q <= cnt_q - c_one;
            end
          end
        end
        S_DRAIN: begin
          if (w_last) begin
            if (mode_q) begin
              state_q <= S_OS_FLUSH;
              cnt_q   <= c_row_len;
            end else begin
              state_q <= S_DONE;
              cnt_q   <= c_one;
            end
          end else begin
            cnt_q <= cnt_q - c_one;
          end
        end
        S_OS_FLUSH: begin
          if (w_last) begin
            state_q <= S_DONE;
            cnt_q   <= c_one;
          end else begin
            cnt_q <= cnt_q - c_one;
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign src_rd_o       = w_feed & ~src_empty_i;
  assign busy_o         = (state_q != S_IDLE);
  assign done_o         = (state_q == S_DONE);
  assign inst_row_o     = inst_q;
  assign os_write_row_o = osw_q;

endmodule
`default_nettype wire
